alu_seq: RTL and testbench

- Parametrised, handshaked successor to the team's 8-bit single-cycle ALU.
- Same eight-operation opcode set: ADD, SUB, MUL, OR, AND, XOR, SLL, SRL; 3-bit encoding 0..7 in that order.
- Adds configurable WIDTH, valid/ready flow control, an iterative shift-add multiplier (FSM) and registered status flags (zero, carry, overflow, negative).
- Sits between an instruction sequencer (upstream) and a writeback/consumer stage (downstream).

---
 rtl/alu_seq.sv | 150 +++++++++++++++
 tb/tb_alu_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with iterative shift-add multiplier and registered flags.
// Optional macro ALU_SAT_EN: ADD/SUB saturate instead of wrapping.
module alu_seq #(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             negative
);

    localparam int MSB = WIDTH - 1;

`ifdef ALU_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_MUL, OP_OR,
        OP_AND, OP_XOR, OP_SLL, OP_SRL
    } opcode_t;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t               state;
    opcode_t              op;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplr;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_next;
    logic [CNT_W-1:0]     cnt;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       diff;
    logic                 shift_big;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_c;
    logic                 alu_v;

    assign op        = opcode_t'(opcode);
    assign sum       = {1'b0, a} + {1'b0, b};
    assign diff      = {1'b0, a} - {1'b0, b};
    assign shift_big = (b >= WIDTH'(WIDTH));
    assign acc_next  = acc + (mplr[0] ? mcand : '0);

    // Single-cycle result and flags for every opcode except MUL
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        unique case (op)
            OP_ADD: begin
                alu_res = sum[MSB:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
                if (SAT && sum[WIDTH]) alu_res = '1;
            end
            OP_SUB: begin
                alu_res = diff[MSB:0];
                alu_c   = diff[WIDTH];
                alu_v   = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
                if (SAT && diff[WIDTH]) alu_res = '0;
            end
            OP_MUL: alu_res = '0;
            OP_OR:  alu_res = a | b;
            OP_AND: alu_res = a & b;
            OP_XOR: alu_res = a ^ b;
            OP_SLL: alu_res = shift_big ? '0 : (a << b);
            OP_SRL: alu_res = shift_big ? '0 : (a >> b);
            default: alu_res = '0;
        endcase
    end

    // Control FSM, multiplier datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            negative  <= 1'b0;
            mcand     <= '0;
            mplr      <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        mcand    <= {{WIDTH{1'b0}}, a};
                        mplr     <= b;
                        if (op == OP_MUL) begin
                            acc   <= '0;
                            cnt   <= CNT_W'(WIDTH);
                            state <= MUL;
                        end else begin
                            result    <= alu_res;
                            zero      <= (alu_res == '0);
                            carry     <= alu_c;
                            overflow  <= alu_v;
                            negative  <= alu_res[MSB];
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                MUL: begin
                    acc   <= acc_next;
                    mcand <= mcand << 1;
                    mplr  <= mplr >> 1;
                    cnt   <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        result    <= acc_next[MSB:0];
                        zero      <= (acc_next[MSB:0] == '0);
                        carry     <= |acc_next[2*WIDTH-1:WIDTH];
                        overflow  <= 1'b0;
                        negative  <= acc_next[MSB];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq against an
// arithmetic reference model.
module tb_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   opcode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         carry;
    logic         overflow;
    logic         negative;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .opcode(opcode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result),
        .zero(zero),
        .carry(carry),
        .overflow(overflow),
        .negative(negative)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint sview(input longint v);
        longint m;
        m = longint'(1) << W;
        return (v >= m / 2) ? v - m : v;
    endfunction

    // Plain-arithmetic statement of the opcode rules
    function automatic void model(input int op, input longint av,
                                  input longint bv, output longint r,
                                  output bit c, output bit v);
        longint m;
        longint h;
        longint s;
        m = longint'(1) << W;
        h = m / 2;
        c = 1'b0;
        v = 1'b0;
        r = 0;
        case (op)
            0: begin
                s = av + bv;
                c = (s >= m);
                r = s % m;
                s = sview(av) + sview(bv);
                v = (s >= h) || (s < -h);
`ifdef ALU_SAT_EN
                if (c) r = m - 1;
`endif
            end
            1: begin
                c = (av < bv);
                r = (av - bv + m) % m;
                s = sview(av) - sview(bv);
                v = (s >= h) || (s < -h);
`ifdef ALU_SAT_EN
                if (c) r = 0;
`endif
            end
            2: begin
                s = av * bv;
                r = s % m;
                c = (s >= m);
            end
            3: r = av | bv;
            4: r = av & bv;
            5: r = av ^ bv;
            6: r = (bv >= W) ? 0 : (av << bv) % m;
            7: r = (bv >= W) ? 0 : (av >> bv);
            default: r = 0;
        endcase
    endfunction

    task automatic run_op(input int op, input int av, input int bv,
                          input int hold);
        longint r;
        bit     c;
        bit     v;
        int     lat;
        bit     busy_ready;
        model(op, longint'(av), longint'(bv), r, c, v);
        @(negedge clk);
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        opcode   = op[2:0];
        a        = av[W-1:0];
        b        = bv[W-1:0];
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        lat        = 1;
        busy_ready = 1'b0;
        while (!out_valid && lat < 40) begin
            if (in_ready) busy_ready = 1'b1;
            a         = W'($urandom);
            b         = W'($urandom);
            opcode    = 3'($urandom);
            out_ready = 1'($urandom);
            @(posedge clk);
            #1;
            lat++;
        end
        out_ready = 1'b0;
        check("latency", lat, (op == 2) ? W + 1 : 1);
        check("in_ready_busy", {31'd0, busy_ready | in_ready}, 32'd0);
        check("result", {24'd0, result}, 32'(r));
        check("zero", {31'd0, zero}, {31'd0, r == 0});
        check("negative", {31'd0, negative}, {31'd0, r >= (1 << (W - 1))});
        check("carry", {31'd0, carry}, {31'd0, c});
        check("overflow", {31'd0, overflow}, {31'd0, v});
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a        = W'($urandom);
            b        = W'($urandom);
            opcode   = 3'($urandom);
            @(posedge clk);
            #1;
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_result", {24'd0, result}, 32'(r));
            check("hold_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("handshake_valid", {31'd0, out_valid}, 32'd0);
        check("handshake_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        bit seen;
        int op;
        int bv;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        opcode    = '0;
        #2;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd1);
        check("rst_result", {24'd0, result}, 32'd0);
        check("rst_carry", {31'd0, carry}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(0, 'h7F, 'h01, 0);
        run_op(0, 'hFF, 'h01, 0);
        run_op(1, 'h03, 'h05, 0);
        run_op(2, 20, 13, 0);
        run_op(2, 12, 10, 0);
        run_op(6, 'h81, 1, 0);
        run_op(7, 'h81, 9, 5);

        // asynchronous reset while holding a result in DONE
        @(negedge clk);
        in_valid = 1'b1;
        opcode   = 3'd0;
        a        = 8'h7F;
        b        = 8'h01;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_zero", {31'd0, zero}, 32'd1);
        check("arst_result", {24'd0, result}, 32'd0);
        check("arst_negative", {31'd0, negative}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // reset in the middle of a multiply
        @(negedge clk);
        in_valid = 1'b1;
        opcode   = 3'd2;
        a        = 8'd20;
        b        = 8'd13;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mrst_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("mrst_no_output", {31'd0, seen}, 32'd0);
        run_op(0, 1, 2, 0);

        for (int i = 0; i < 60; i++) begin
            op = int'($urandom_range(0, 7));
            if (op >= 6 && $urandom_range(0, 1) == 1)
                bv = int'($urandom_range(0, 10));
            else
                bv = int'($urandom_range(0, 255));
            run_op(op, int'($urandom_range(0, 255)), bv,
                   int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
